// File: rtl/bp_cfg_boot_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : bp_cfg_boot_sequencer
//  Purpose  : Post-reset config-bus sequencer. For every core it writes
//             freeze, core id, the CCE microcode image, CCE mode, then unfreeze.
//  Revision : 1.0  initial release
// ============================================================================
module bp_cfg_boot_sequencer #(
  parameter int num_core_p       = 1,
  parameter int cce_pc_width_p   = 8,
  parameter int cfg_addr_width_p = 16,
  parameter int cfg_data_width_p = 64,
  parameter int core_id_width_p  = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  output logic                        cfg_v_o,
  input  logic                        cfg_ready_i,
  output logic [core_id_width_p-1:0]  cfg_core_o,
  output logic [cfg_addr_width_p-1:0] cfg_addr_o,
  output logic [cfg_data_width_p-1:0] cfg_data_o,
  output logic                        ucode_v_o,
  output logic [cce_pc_width_p-1:0]   ucode_addr_o,
  input  logic [cfg_data_width_p-1:0] ucode_data_i,
  output logic                        done_o
);

  localparam logic [2:0] S_RESET    = 3'd0;
  localparam logic [2:0] S_FREEZE   = 3'd1;
  localparam logic [2:0] S_CORE_ID  = 3'd2;
  localparam logic [2:0] S_UC_RD    = 3'd3;
  localparam logic [2:0] S_UC_WR    = 3'd4;
  localparam logic [2:0] S_MODE     = 3'd5;
  localparam logic [2:0] S_UNFREEZE = 3'd6;
  localparam logic [2:0] S_DONE     = 3'd7;

  localparam logic [cfg_addr_width_p-1:0] ADDR_FREEZE  = '0;
  localparam logic [cfg_addr_width_p-1:0] ADDR_CORE_ID = cfg_addr_width_p'(4);
  localparam logic [cfg_addr_width_p-1:0] ADDR_MODE    = cfg_addr_width_p'(8);
  localparam logic [cfg_addr_width_p-1:0] ADDR_UCODE   = cfg_addr_width_p'(32'h8000);
  localparam logic [cfg_data_width_p-1:0] DATA_ONE     = cfg_data_width_p'(1);
  localparam logic [core_id_width_p-1:0]  LAST_CORE    = core_id_width_p'(num_core_p - 1);

  if (cce_pc_width_p >= cfg_addr_width_p) begin : g_width_check
    $error("cce_pc_width_p must be smaller than cfg_addr_width_p");
  end

  logic [2:0]                  state_q, state_d;
  logic [core_id_width_p-1:0]  core_q, core_d;
  logic [cce_pc_width_p-1:0]   word_q, word_d;
  logic                        fresh_q;
  logic [cfg_data_width_p-1:0] ucode_q;
  logic [cfg_data_width_p-1:0] uc_data;
  logic                        write_st;
  logic                        xfer;

  assign write_st = (state_q == S_FREEZE) || (state_q == S_CORE_ID) ||
                    (state_q == S_UC_WR)  || (state_q == S_MODE)    ||
                    (state_q == S_UNFREEZE);
  assign xfer     = write_st & cfg_ready_i;

  assign cfg_v_o      = write_st;
  assign cfg_core_o   = core_q;
  assign ucode_v_o    = (state_q == S_UC_RD);
  assign ucode_addr_o = word_q;
  assign done_o       = (state_q == S_DONE);

  // ROM data is live only in the first S_UC_WR cycle; later stall cycles use the copy.
  assign uc_data = fresh_q ? ucode_data_i : ucode_q;

  always_comb begin
    state_d    = state_q;
    core_d     = core_q;
    word_d     = word_q;
    cfg_addr_o = '0;
    cfg_data_o = '0;
    case (state_q)
      S_RESET: state_d = S_FREEZE;
      S_FREEZE: begin
        cfg_addr_o = ADDR_FREEZE;
        cfg_data_o = DATA_ONE;
        if (xfer) state_d = S_CORE_ID;
      end
      S_CORE_ID: begin
        cfg_addr_o = ADDR_CORE_ID;
        cfg_data_o = cfg_data_width_p'(core_q);
        if (xfer) state_d = S_UC_RD;
      end
      S_UC_RD: state_d = S_UC_WR;
      S_UC_WR: begin
        cfg_addr_o = ADDR_UCODE + cfg_addr_width_p'(word_q);
        cfg_data_o = uc_data;
        if (xfer) begin
          if (word_q == '1) begin
            word_d  = '0;
            state_d = S_MODE;
          end else begin
            word_d  = word_q + cce_pc_width_p'(1);
            state_d = S_UC_RD;
          end
        end
      end
      S_MODE: begin
        cfg_addr_o = ADDR_MODE;
        cfg_data_o = DATA_ONE;
        if (xfer) state_d = S_UNFREEZE;
      end
      S_UNFREEZE: begin
        cfg_addr_o = ADDR_FREEZE;
        cfg_data_o = '0;
        if (xfer) begin
          if (core_q == LAST_CORE) begin
            state_d = S_DONE;
          end else begin
            core_d  = core_q + core_id_width_p'(1);
            state_d = S_FREEZE;
          end
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_RESET;
      core_q  <= '0;
      word_q  <= '0;
      fresh_q <= 1'b0;
      ucode_q <= '0;
    end else begin
      state_q <= state_d;
      core_q  <= core_d;
      word_q  <= word_d;
      fresh_q <= ucode_v_o;
      if (fresh_q) ucode_q <= ucode_data_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bp_cfg_boot_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bp_cfg_boot_sequencer
//  Purpose  : Self-checking bench: two configurations, directed and random stalls.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bp_cfg_boot_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_a, reset_b, cfg_ready;

  // Configuration A: two cores, four microcode words
  logic        a_v, a_uv, a_done;
  logic [0:0]  a_core;
  logic [15:0] a_addr;
  logic [63:0] a_data, a_rom;
  logic [1:0]  a_uaddr;

  bp_cfg_boot_sequencer #(
    .num_core_p(2), .cce_pc_width_p(2), .cfg_addr_width_p(16), .cfg_data_width_p(64)
  ) u_dut_a (
    .clk_i(clk), .reset_i(reset_a), .cfg_v_o(a_v), .cfg_ready_i(cfg_ready),
    .cfg_core_o(a_core), .cfg_addr_o(a_addr), .cfg_data_o(a_data),
    .ucode_v_o(a_uv), .ucode_addr_o(a_uaddr), .ucode_data_i(a_rom), .done_o(a_done)
  );

  always @(posedge clk) if (a_uv) a_rom <= 64'hA0 + 64'(a_uaddr);

  // Configuration B: one core, two microcode words
  logic        b_v, b_uv, b_done;
  logic [0:0]  b_core;
  logic [15:0] b_addr;
  logic [63:0] b_data, b_rom;
  logic [0:0]  b_uaddr;

  bp_cfg_boot_sequencer #(
    .num_core_p(1), .cce_pc_width_p(1), .cfg_addr_width_p(16), .cfg_data_width_p(64)
  ) u_dut_b (
    .clk_i(clk), .reset_i(reset_b), .cfg_v_o(b_v), .cfg_ready_i(cfg_ready),
    .cfg_core_o(b_core), .cfg_addr_o(b_addr), .cfg_data_o(b_data),
    .ucode_v_o(b_uv), .ucode_addr_o(b_uaddr), .ucode_data_i(b_rom), .done_o(b_done)
  );

  always @(posedge clk) if (b_uv) b_rom <= 64'hB0 + 64'(b_uaddr);

  logic        sel;
  logic        w_v, w_uv, w_done;
  logic [7:0]  w_core, w_uaddr;
  logic [15:0] w_addr;
  logic [63:0] w_data;

  always_comb begin
    if (sel) begin
      w_v = b_v; w_uv = b_uv; w_done = b_done; w_core = 8'(b_core);
      w_uaddr = 8'(b_uaddr); w_addr = b_addr; w_data = b_data;
    end else begin
      w_v = a_v; w_uv = a_uv; w_done = a_done; w_core = 8'(a_core);
      w_uaddr = 8'(a_uaddr); w_addr = a_addr; w_data = a_data;
    end
  end

  typedef struct {
    logic [7:0]  core;
    logic [15:0] addr;
    logic [63:0] data;
  } wr_t;

  wr_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int mode, widx, stall_this, stall_cycles, cyc, first_v, done_cyc, uc_exp, els;
  logic        prev_stall, prev_uv, last_xfer;
  logic [7:0]  prev_core;
  logic [15:0] prev_addr;
  logic [63:0] prev_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_reset(input logic v);
    if (sel) reset_b = v;
    else     reset_a = v;
  endtask

  // Expected write list built straight from the per-core recipe.
  task automatic build(input int n, input int e, input logic [63:0] base);
    wr_t w;
    exp_q.delete();
    for (int c = 0; c < n; c++) begin
      w.core = 8'(c);
      w.addr = 16'h0000; w.data = 64'd1;       exp_q.push_back(w);
      w.addr = 16'h0004; w.data = 64'(c);      exp_q.push_back(w);
      for (int i = 0; i < e; i++) begin
        w.addr = 16'(32'h8000 + i); w.data = base + 64'(i); exp_q.push_back(w);
      end
      w.addr = 16'h0008; w.data = 64'd1;       exp_q.push_back(w);
      w.addr = 16'h0000; w.data = 64'd0;       exp_q.push_back(w);
    end
  endtask

  // One clock cycle: drive ready, then check handshake and protocol rules.
  task automatic step();
    logic xf;
    @(negedge clk);
    case (mode)
      1:       cfg_ready = !(w_v && ((widx + 1) % 3 == 0) && (stall_this < 3));
      2:       cfg_ready = ($urandom_range(0, 3) != 0);
      default: cfg_ready = 1'b1;
    endcase
    if (prev_stall) begin
      check("stall_core", 64'(w_core), 64'(prev_core));
      check("stall_addr", 64'(w_addr), 64'(prev_addr));
      check("stall_data", w_data, prev_data);
    end
    xf = w_v && cfg_ready;
    last_xfer = xf;
    if (xf) begin
      if (widx < exp_q.size()) begin
        check($sformatf("wr%0d_core", widx), 64'(w_core), 64'(exp_q[widx].core));
        check($sformatf("wr%0d_addr", widx), 64'(w_addr), 64'(exp_q[widx].addr));
        check($sformatf("wr%0d_data", widx), w_data, exp_q[widx].data);
      end else begin
        check("extra_write", 64'(widx), 64'(exp_q.size()));
      end
      widx++;
      stall_this = 0;
    end else if (w_v) begin
      stall_cycles++;
      stall_this++;
    end
    prev_stall = w_v && !cfg_ready;
    prev_core  = w_core;
    prev_addr  = w_addr;
    prev_data  = w_data;
    if (w_uv) begin
      check("uc_back_to_back", 64'(prev_uv), 64'd0);
      check("uc_addr", 64'(w_uaddr), 64'(uc_exp));
      uc_exp = (uc_exp + 1) % els;
    end
    prev_uv = w_uv;
    if (w_done) begin
      check("v_after_done", 64'(w_v), 64'd0);
      if (done_cyc < 0) done_cyc = cyc;
    end
    if (w_v && first_v < 0) first_v = cyc;
    cyc++;
  endtask

  task automatic run_seq(input int n, input int e, input logic [63:0] base,
                         input int md, input int abort_idx, input int budget);
    build(n, e, base);
    mode = md; els = e;
    widx = 0; stall_this = 0; stall_cycles = 0; uc_exp = 0;
    first_v = -1; done_cyc = -1;
    prev_stall = 1'b0; prev_uv = 1'b0; last_xfer = 1'b0;
    cfg_ready = 1'b1;
    set_reset(1'b1);
    repeat (2) @(posedge clk);
    #1 set_reset(1'b0);
    cyc = 0;
    while (cyc < budget) begin
      step();
      if (abort_idx >= 0 && last_xfer && widx == abort_idx + 1) return;
      if (done_cyc >= 0) break;
    end
    check("first_v_cycle", 64'(first_v), 64'd1);
    check("write_count", 64'(widx), 64'(exp_q.size()));
    check("done_cycle", 64'(done_cyc), 64'(1 + n * (4 + 2 * e) + stall_cycles));
  endtask

  initial begin
    sel = 1'b0; mode = 0; els = 1;
    reset_a = 1'b1; reset_b = 1'b1; cfg_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_a_v",     64'(a_v), 64'd0);
    check("rst_a_core",  64'(a_core), 64'd0);
    check("rst_a_addr",  64'(a_addr), 64'd0);
    check("rst_a_data",  a_data, 64'd0);
    check("rst_a_uv",    64'(a_uv), 64'd0);
    check("rst_a_uaddr", 64'(a_uaddr), 64'd0);
    check("rst_a_done",  64'(a_done), 64'd0);
    check("rst_b_done",  64'(b_done), 64'd0);
    check("rst_b_v",     64'(b_v), 64'd0);

    // Ready tied high
    run_seq(2, 4, 64'hA0, 0, -1, 200);
    check("nostall_done_25", 64'(done_cyc), 64'd25);

    // Ready low for 3 cycles on every third write: 5 stalled writes
    run_seq(2, 4, 64'hA0, 1, -1, 300);
    check("stall_cycles_15", 64'(stall_cycles), 64'd15);
    check("stall_done_40", 64'(done_cyc), 64'd40);

    // Random ready
    run_seq(2, 4, 64'hA0, 2, -1, 500);

    // Reset the cycle after the third microcode write of core 1
    run_seq(2, 4, 64'hA0, 0, 12, 200);
    @(posedge clk);
    #1 set_reset(1'b1);
    step();
    step();
    check("midrst_v", 64'(w_v), 64'd0);
    check("midrst_done", 64'(w_done), 64'd0);
    run_seq(2, 4, 64'hA0, 0, -1, 200);
    check("restart_done_25", 64'(done_cyc), 64'd25);

    // Boundary: one core, two microcode words
    reset_a = 1'b1;
    sel = 1'b1;
    run_seq(1, 2, 64'hB0, 0, -1, 100);
    check("bnd_writes_6", 64'(widx), 64'd6);
    check("bnd_done_9", 64'(done_cyc), 64'd9);
    repeat (100) step();
    check("bnd_hold_done", 64'(w_done), 64'd1);
    check("bnd_hold_v", 64'(w_v), 64'd0);
    check("bnd_no_more_writes", 64'(widx), 64'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
